ibuf_sync_filter: RTL and testbench

- Receive-side counterpart of the tri-state output pad buffer.
- Takes an asynchronous pad input, synchronizes it into clock domain C, and rejects glitches shorter than a programmable number of cycles.
- Produces a stable level plus single-cycle rise/fall strobes and a saturating count of rejected glitches.
- Sits directly behind the input pad, feeding control logic that must not see metastable or bouncing levels.

---
 rtl/ibuf_pkg.sv | 17 +
 rtl/ibuf_sync_chain.sv | 22 ++
 rtl/ibuf_sync_filter.sv | 69 ++++++
 tb/tb_ibuf_sync_filter.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/ibuf_pkg.sv
// ibuf_pkg: shared constants and elaboration helpers for pad-input blocks
package ibuf_pkg;
    localparam int SYNC_MIN = 2;
    localparam int SYNC_MAX = 4;
    localparam int FILT_MAX = 255;
    function automatic int clog2(input int v);
        int r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
    function automatic bit sync_ok(input int n);
        return n >= SYNC_MIN && n <= SYNC_MAX;
    endfunction
    function automatic bit filt_ok(input int n);
        return n >= 1 && n <= FILT_MAX;
    endfunction
endpackage

// File: rtl/ibuf_sync_chain.sv
// ibuf_sync_chain: multi-flop synchronizer bringing an async pad level into the clock domain
module ibuf_sync_chain
    import ibuf_pkg::*;
#(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    if (!sync_ok(STAGES)) begin : g_bad_stages
        $error("ibuf_sync_chain: STAGES out of range");
    end
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_s;
    // shift the pad level through the chain every edge; reset loads the idle level
    always_ff @(posedge i_clk) begin
        r_s <= i_rst ? {STAGES{INIT}} : {r_s[STAGES-2:0], i_d};
    end
    assign o_q = r_s[STAGES-1];
endmodule

// File: rtl/ibuf_sync_filter.sv
// ibuf_sync_filter: synchronized, glitch-filtered pad input with edge strobes and glitch counter
module ibuf_sync_filter
    import ibuf_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   FILT_CYCLES = 4,
    parameter logic INIT        = 1'b0
) (
    input  logic       C,
    input  logic       R,
    input  logic       CE,
    input  logic       I,
    input  logic       GCLR,
    output logic       O,
    output logic       RISE,
    output logic       FALL,
    output logic [7:0] GLITCH_CNT
);
    if (!filt_ok(FILT_CYCLES)) begin : g_bad_filt
        $error("ibuf_sync_filter: FILT_CYCLES out of range");
    end
    localparam int CW = clog2(FILT_CYCLES + 1);
    logic          w_sync;
    logic          w_diff;
    logic          w_fire;
    logic          w_reject;
    logic [CW-1:0] w_cnt_inc;
    logic [CW-1:0] r_cnt;
    logic          r_o;
    logic          r_rise;
    logic          r_fall;
    logic [7:0]    r_gc;
    ibuf_sync_chain #(
        .STAGES(SYNC_STAGES),
        .INIT  (INIT)
    ) u_sync (
        .i_clk(C),
        .i_rst(R),
        .i_d  (I),
        .o_q  (w_sync)
    );
    assign w_diff    = w_sync != r_o;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_fire    = w_diff && (w_cnt_inc == CW'(FILT_CYCLES));
    assign w_reject  = !w_diff && (r_cnt != '0);
    // persistence filter: a new level must hold FILT_CYCLES enabled cycles; aborted runs count as glitches
    always_ff @(posedge C) begin
        if (R) begin
            r_o    <= INIT;
            r_cnt  <= '0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
            r_gc   <= '0;
        end else begin
            r_rise <= CE && w_fire && w_sync;
            r_fall <= CE && w_fire && !w_sync;
            if (CE) begin
                r_cnt <= (w_diff && !w_fire) ? w_cnt_inc : '0;
                if (w_fire) r_o <= w_sync;
            end
            if (GCLR) r_gc <= '0;
            else if (CE && w_reject && r_gc != 8'hFF) r_gc <= r_gc + 8'd1;
        end
    end
    assign O          = r_o;
    assign RISE       = r_rise;
    assign FALL       = r_fall;
    assign GLITCH_CNT = r_gc;
endmodule

// File: tb/tb_ibuf_sync_filter.sv
// tb_ibuf_sync_filter: directed scenarios plus randomized run against a delay-line/run-length model
module tb_ibuf_sync_filter;
    localparam int S = 2;
    localparam int F = 4;
    logic       clk = 1'b0;
    logic       R = 1'b1, CE = 1'b1, I = 1'b0, GCLR = 1'b0;
    logic       O, RISE, FALL;
    logic [7:0] GC;
    logic       Rb = 1'b1, Ib = 1'b1;
    logic       Ob, RISEb, FALLb;
    logic [7:0] GCb;
    int         total = 0;
    int         bad = 0;
    int         n = 0;
    int         last_rst = 0;
    bit         hist [0:7];
    bit         m_o = 1'b0, m_rise = 1'b0, m_fall = 1'b0;
    int         m_run = 0;
    int         m_gc = 0;

    always #5 clk = ~clk;

    ibuf_sync_filter #(.SYNC_STAGES(S), .FILT_CYCLES(F), .INIT(1'b0)) dut_a (
        .C(clk), .R(R), .CE(CE), .I(I), .GCLR(GCLR),
        .O(O), .RISE(RISE), .FALL(FALL), .GLITCH_CNT(GC)
    );

    ibuf_sync_filter #(.SYNC_STAGES(3), .FILT_CYCLES(1), .INIT(1'b1)) dut_b (
        .C(clk), .R(Rb), .CE(1'b1), .I(Ib), .GCLR(1'b0),
        .O(Ob), .RISE(RISEb), .FALL(FALLb), .GLITCH_CNT(GCb)
    );

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got=%0d expected=%0d", tag, n, got, exp);
        end
    endtask

    // one clock: update the reference model with the inputs seen at the edge, then compare
    task automatic tick();
        bit so;
        @(posedge clk);
        n++;
        hist[n % 8] = I;
        so = (n - S > last_rst) ? hist[(n - S) % 8] : 1'b0;
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (R) begin
            last_rst = n;
            m_o = 1'b0;
            m_run = 0;
            m_gc = 0;
        end else begin
            if (CE) begin
                if (so == m_o) begin
                    if (m_run > 0) m_gc = (m_gc < 255) ? m_gc + 1 : 255;
                    m_run = 0;
                end else if (m_run + 1 == F) begin
                    m_o = so;
                    m_rise = so;
                    m_fall = !so;
                    m_run = 0;
                end else begin
                    m_run++;
                end
            end
            if (GCLR) m_gc = 0;
        end
        @(negedge clk);
        chk("model_o", O, m_o);
        chk("model_rise", RISE, m_rise);
        chk("model_fall", FALL, m_fall);
        chk("model_gcnt", GC, m_gc);
    endtask

    initial begin
        int a;
        repeat (3) tick();
        chk("rst_o", O, 0);
        chk("rst_gcnt", GC, 0);
        chk("rst_strobes", RISE | FALL, 0);
        chk("b_rst_o", Ob, 1);
        R = 1'b0;
        Rb = 1'b0;
        I = 1'b1;
        Ib = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            chk("step_o", O, k >= 6);
            chk("step_rise", RISE, k == 6);
            chk("step_fall", FALL, 0);
            chk("b_o", Ob, k < 4);
            chk("b_fall", FALLb, k == 4);
            chk("b_rise", RISEb, 0);
            chk("b_gcnt", GCb, 0);
        end
        chk("step_gcnt", GC, 0);
        I = 1'b0;
        repeat (8) tick();
        for (int g = 0; g < 300; g++) begin
            I = 1'b1;
            repeat (3) tick();
            I = 1'b0;
            repeat (3) tick();
            chk("glitch_o", O, 0);
            if (g == 0) chk("glitch_one", GC, 1);
        end
        chk("glitch_sat", GC, 255);
        I = 1'b1;
        repeat (3) tick();
        I = 1'b0;
        repeat (2) tick();
        GCLR = 1'b1;
        tick();
        GCLR = 1'b0;
        chk("gclr_wins", GC, 0);
        tick();
        chk("gclr_after", GC, 0);
        I = 1'b1;
        repeat (8) tick();
        chk("pre_fall_o", O, 1);
        I = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            CE = !(k >= 3 && k <= 5);
            tick();
            chk("ce_fall_o", O, k < 9);
            chk("ce_fall_strobe", FALL, k == 9);
        end
        CE = 1'b1;
        repeat (4) tick();
        I = 1'b1;
        for (int k = 1; k <= 11; k++) begin
            R = (k == 4);
            tick();
            chk("rst_mid_o", O, k >= 10);
            chk("rst_mid_rise", RISE, k == 10);
        end
        R = 1'b0;
        for (int k = 0; k < 4000; k++) begin
            a = ((k / 250) % 2 == 0) ? 15 : 45;
            if ($urandom_range(0, 99) < a) I = !I;
            CE = $urandom_range(0, 99) < 85;
            GCLR = $urandom_range(0, 99) < 2;
            R = $urandom_range(0, 999) < 5;
            tick();
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
